// File: rtl/aes_key_schedule.sv
// aes_key_schedule: one-word-per-cycle AES-128/192/256 key expansion into a register array,
// with a registered round-key read port in forward or reverse round order.
module softbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // entry 0 sits in the top byte, so byte b lives at bit 8*(255-b)
    assign o_byte = TABLE[{~i_byte, 3'b000} +: 8];
endmodule

module aes_key_schedule #(
    parameter int MAX_WORDS       = 60,
    parameter bit RD_ZERO_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [1:0]   i_key_len,
    input  logic [255:0] i_key_in,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_key_valid,
    output logic         o_err,
    output logic [3:0]   o_nr,
    input  logic [3:0]   i_rd_round,
    input  logic         i_rd_dir,
    output logic [127:0] o_rd_key
);
    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;
    state_t       r_state;
    logic [1:0]   r_len;
    logic [255:0] r_key;
    logic [5:0]   r_i;
    logic [2:0]   r_cnt;
    logic [7:0]   r_rcon;
    logic         r_busy, r_done, r_valid, r_err;
    logic [3:0]   r_nr;
    logic [127:0] r_rd_key;
    logic [31:0]  r_w [MAX_WORDS];
    logic [5:0]   w_nk, w_last, w_base;
    logic [2:0]   w_cnt_max;
    logic [31:0]  w_prev, w_sin, w_sub, w_temp, w_new;
    logic [3:0]   w_k;
    logic         w_rd_ok;
    assign w_nk      = 6'd4 + {3'b000, r_len, 1'b0};
    assign w_cnt_max = 3'd3 + {r_len, 1'b0};
    assign w_last    = 6'd43 + {1'b0, r_len, 3'b000};
    assign w_prev    = r_w[r_i - 6'd1];
    assign w_sin     = (r_cnt == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        softbox u_sbox (.i_byte(w_sin[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
    end
    // r_cnt is i mod Nk; lane 4 of an AES-256 block takes the extra SubWord
    assign w_temp  = (r_cnt == 3'd0) ? (w_sub ^ {r_rcon, 24'h000000}) :
                     (r_len == 2'd2 && r_cnt == 3'd4) ? w_sub : w_prev;
    assign w_new   = r_w[r_i - w_nk] ^ w_temp;
    assign w_k     = i_rd_dir ? r_nr - i_rd_round : i_rd_round;
    assign w_base  = {w_k, 2'b00};
    assign w_rd_ok = !RD_ZERO_INVALID || (r_valid && i_rd_round <= r_nr);
    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            for (int j = 0; j < 8; j++)
                if (j < int'(w_nk)) r_w[j] <= r_key[255 - 32*j -: 32];
        end else if (r_state == GEN)
            r_w[r_i] <= w_new;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_len    <= 2'd0;
            r_key    <= '0;
            r_i      <= 6'd0;
            r_cnt    <= 3'd0;
            r_rcon   <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_nr     <= 4'd0;
            r_rd_key <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_key <= w_rd_ok ? {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]} : '0;
            case (r_state)
                IDLE: if (i_start) begin
                    if (i_key_len == 2'b11) r_err <= 1'b1;
                    else begin
                        r_len   <= i_key_len;
                        r_key   <= i_key_in;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_i     <= w_nk;
                    r_cnt   <= 3'd0;
                    r_rcon  <= 8'h01;
                    r_valid <= 1'b0;
                    r_state <= GEN;
                end
                GEN: begin
                    r_i   <= r_i + 6'd1;
                    r_cnt <= (r_cnt == w_cnt_max) ? 3'd0 : r_cnt + 3'd1;
                    if (r_cnt == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                    if (r_i == w_last) r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_nr    <= 4'd10 + {1'b0, r_len, 1'b0};
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_key_valid = r_valid;
    assign o_err       = r_err;
    assign o_nr        = r_nr;
    assign o_rd_key    = r_rd_key;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed AES key-schedule vectors checked against a FIPS-197 style
// reference model (S-box derived from GF(2^8) inversion) on every cycle.
module tb_aes_key_schedule;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic [1:0] i_key_len = 2'd0;
    logic [255:0] i_key_in = '0;
    logic [3:0] i_rd_round = 4'd0;
    logic i_rd_dir = 1'b0;
    logic o_busy, o_done, o_key_valid, o_err;
    logic [3:0] o_nr;
    logic [127:0] o_rd_key;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_w [60];
    logic [31:0] p_w [60];
    logic e_busy = 1'b0, e_done = 1'b0, e_valid = 1'b0, e_err = 1'b0;
    logic [3:0] e_nr = 4'd0, p_nr = 4'd0;
    logic [127:0] e_rd = '0;
    int m_age = 0, m_lat = 0;

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_key_len(i_key_len), .i_key_in(i_key_in),
        .o_busy(o_busy), .o_done(o_done), .o_key_valid(o_key_valid), .o_err(o_err), .o_nr(o_nr),
        .i_rd_round(i_rd_round), .i_rd_dir(i_rd_dir), .o_rd_key(o_rd_key)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse (b^254) then the affine map
    function automatic logic [7:0] sbox_m(input logic [7:0] b);
        logic [7:0] inv, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        s = inv ^ 8'h63;
        for (int r = 1; r < 5; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) p_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = p_w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) t = sub_word(t);
            p_w[i] = p_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] rd_model(input logic [3:0] r, input logic d);
        int k;
        if (!e_valid || r > e_nr) return '0;
        k = d ? int'(e_nr) - int'(r) : int'(r);
        return {m_w[4*k], m_w[4*k+1], m_w[4*k+2], m_w[4*k+3]};
    endfunction

    // cycle-level model: outputs expected after each rising edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            e_busy = 0; e_done = 0; e_valid = 0; e_err = 0; e_nr = 0; e_rd = '0;
        end else begin
            e_rd = rd_model(i_rd_round, i_rd_dir);
            e_done = 0;
            e_err = 0;
            if (e_busy) begin
                m_age++;
                if (m_age == 1) e_valid = 0;
                if (m_age == m_lat) begin
                    e_busy = 0; e_done = 1; e_valid = 1; e_nr = p_nr;
                    for (int i = 0; i < 60; i++) m_w[i] = p_w[i];
                end
            end else if (i_start && i_key_len == 2'b11) e_err = 1;
            else if (i_start) begin
                e_busy = 1;
                m_age = 0;
                p_nr = 4'(10 + 2 * int'(i_key_len));
                m_lat = 4 * (int'(p_nr) + 1) - (int'(p_nr) - 6) + 2;
                expand(i_key_in, int'(p_nr) - 6);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("busy", 128'(o_busy), 128'(e_busy));
            chk("done", 128'(o_done), 128'(e_done));
            chk("key_valid", 128'(o_key_valid), 128'(e_valid));
            chk("err", 128'(o_err), 128'(e_err));
            chk("nr", 128'(o_nr), 128'(e_nr));
            chk("rd_key", o_rd_key, e_rd);
        end
    end

    task automatic run(input logic [1:0] len, input logic [255:0] key, input int lat, input int poke);
        int n;
        @(negedge clk);
        i_start = 1'b1; i_key_len = len; i_key_in = key;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (o_done) break;
            i_start = (n == poke);
            if (n == poke) begin i_key_len = 2'b00; i_key_in = ~key; end
        end
        i_start = 1'b0;
        chk("done_latency", 128'(n), 128'(lat));
    endtask

    task automatic rd(input logic [3:0] r, input logic d, output logic [127:0] k);
        @(negedge clk);
        i_rd_round = r; i_rd_dir = d;
        @(negedge clk);
        k = o_rd_key;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {o_busy, o_done, o_key_valid, o_err, o_nr, o_rd_key}, '0);
    endtask

    initial begin
        logic [127:0] k;
        chk("model_sbox_00", 128'(sbox_m(8'h00)), 128'h63);
        chk("model_sbox_53", 128'(sbox_m(8'h53)), 128'hed);
        expand(K128, 4);
        chk("model_w4_128", 128'(p_w[4]), 128'ha0fafe17);
        chk("model_w43_128", 128'(p_w[43]), 128'hb6630ca6);
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset");

        run(2'b00, K128, 42, 0);
        chk("nr_128", 128'(o_nr), 128'd10);
        rd(4'd1, 1'b0, k);  chk("aes128_r1_w0", 128'(k[127:96]), 128'ha0fafe17);
        rd(4'd10, 1'b0, k); chk("aes128_r10", k, R10_128);
        rd(4'd0, 1'b1, k);  chk("aes128_rev0", k, R10_128);

        @(negedge clk); i_start = 1'b1; i_key_len = 2'b11;
        @(negedge clk); i_start = 1'b0;
        chk("illegal_err", 128'(o_err), 128'd1);
        chk("illegal_busy", 128'(o_busy), 128'd0);
        @(negedge clk);
        chk("illegal_err_clear", 128'(o_err), 128'd0);
        rd(4'd10, 1'b0, k); chk("held_after_illegal", k, R10_128);

        run(2'b01, K192, 48, 20);
        chk("nr_192", 128'(o_nr), 128'd12);
        rd(4'd1, 1'b0, k);  chk("aes192_w6", 128'(k[63:32]), 128'hfe0c91f7);
        rd(4'd12, 1'b0, k); chk("aes192_r12_w3", 128'(k[31:0]), 128'h01002202);

        run(2'b10, K256, 54, 0);
        rd(4'd2, 1'b0, k);  chk("aes256_w8", 128'(k[127:96]), 128'h9ba35411);
        rd(4'd14, 1'b0, k); chk("aes256_r14", k, R14_256);
        rd(4'd0, 1'b1, k);  chk("aes256_rev0", k, R14_256);
        rd(4'd15, 1'b0, k); chk("aes256_r15_zero", k, 128'h0);

        @(negedge clk); i_start = 1'b1; i_key_len = 2'b10; i_key_in = K256;
        @(negedge clk); i_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", 128'(o_busy), 128'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset_mid_gen");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(2'b00, K128, 42, 0);
        rd(4'd10, 1'b0, k); chk("restart_aes128_r10", k, R10_128);
        rd(4'd1, 1'b0, k);  chk("restart_aes128_r1_w0", 128'(k[127:96]), 128'ha0fafe17);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, mode-selectable AES key expansion engine. It generates one 32-bit schedule word per clock for AES-128, AES-192 or AES-256, and stores the full schedule, up to 60 words, in an internal register array. It replaces per-round combinational key logic in both the encryption and decryption datapaths. Round keys are served through a registered read port in either forward (encrypt) or reverse (decrypt) round order.

## Interface
- MAX_WORDS, 60: schedule storage depth in 32-bit words; must be ≥ 60 to support AES-256.
- RD_ZERO_INVALID, 1: when 1, rd_key reads as zero whenever key_valid is low or the requested round is out of range.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to expand key_in using key_len.
- key_len  in  2  mode: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
- key_in  in  256  cipher key, MSB-aligned: 128-bit key in [255:128], 192-bit key in [255:64].
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- key_valid  out  1  high while a complete schedule is held.
- err  out  1  one-cycle pulse when a start is rejected.
- nr  out  4  round count of the held schedule (10, 12 or 14).
- rd_round  in  4  round index requested.
- rd_dir  in  1  0 = forward order (round r), 1 = reverse order (round Nr−r).
- rd_key  out  128  registered round key, words w[4k]..w[4k+3] packed [127:96]..[31:0].

## Operation
- States: IDLE, LOAD, GEN, DONE.
- IDLE:
  - start with a legal key_len: latch key_len and key_in, then go to LOAD.
  - start with key_len = 11: pulse err, stay in IDLE, and leave any held schedule and key_valid untouched.
- LOAD (1 cycle):
  - Write w[0..Nk−1] from key_in.
  - Set word index i = Nk, Rcon = 01.
  - Clear key_valid.
  - Go to GEN.
- GEN (one word per cycle): compute temp from w[i−1], then w[i] = w[i−Nk] ^ temp.
  - If i mod Nk == 0: temp = SubWord(RotWord(w[i−1])) ^ {Rcon, 24'h0}, and Rcon advances by the GF(2^8) xtime (…80 → 1b → 36).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(w[i−1]).
  - Else: temp = w[i−1].
  - SubWord uses four instances of the team's softbox byte S-box, one per byte lane.
  - i mod Nk is tracked with a wrap counter; no divider.
- Exit from GEN: after writing w[4·Nr+3], go to DONE.
- DONE (1 cycle): pulse done, set key_valid, load nr, return to IDLE.
- start while busy: ignored. No err pulse, no effect on the expansion in progress.
- Read port, every cycle:
  - Effective round k = rd_dir ? nr − rd_round : rd_round.
  - rd_key ← {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
  - If rd_round > nr, or key_valid is low (with RD_ZERO_INVALID = 1), rd_key ← 0.
- Reset mid-expansion:
  - Return to IDLE; key_valid, busy, done and err go low; nr ← 0.
  - Storage contents are don't-care.
- A new legal start after completion overwrites the schedule. key_valid stays low until the new done.

## Timing
- Reset values: busy 0, done 0, key_valid 0, err 0, nr 0, rd_key 0, state IDLE.
- start sampled high at edge E0 → LOAD during the cycle after E0. busy is high from after E0 until the DONE cycle ends.
- GEN cycles = 4·(Nr+1) − Nk: 40 (AES-128), 46 (AES-192), 52 (AES-256).
- Latency from the sampling edge of start to done high: 2 + GEN cycles, i.e. 42, 48 or 54 cycles.
- key_valid rises in the same cycle as done.
- Read latency: 1 cycle. rd_key reflects the rd_round/rd_dir sampled at the previous edge.
- err: high for exactly the cycle after an illegal start was sampled.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done exactly 42 cycles after start.
  - Forward round 1 → rd_key[127:96] = a0fafe17.
  - Forward round 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Reverse round 0 returns the same value as forward round 10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at 48 cycles, nr = 12.
  - w[6] = fe0c91f7.
  - Forward round 12, word 3 = 01002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at 54 cycles.
  - w[8] = 9ba35411.
  - Forward round 14 → fe4890d1e6188d0b046df344706c631e.
  - rd_round = 15 → rd_key = 0.
- Illegal and overlapping starts:
  - key_len = 11 start → err pulse, busy stays 0, previous schedule still readable.
  - start asserted mid-GEN → ignored, done timing unchanged.
- Reset and restart:
  - rst_n pulsed low during GEN of AES-256 → all outputs 0 immediately.
  - After release, an AES-128 start yields the correct schedule in 42 cycles.
